// File: rtl/instr_prefetch_buffer_pkg.sv
// Shared types for the instruction prefetch buffer.
// Holds the fetch FSM state enum and the FIFO entry layout.
package instr_prefetch_buffer_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FLUSH
  } state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] data;
  } fetch_entry_t;

  function automatic logic [31:0] word_addr(
    input logic [31:0] pc
  );
    return {2'b00, pc[31:2]};
  endfunction

endpackage

// File: rtl/prefetch_fifo.sv
// Prefetch FIFO: DEPTH entries of {pc, data}, registered head.
// Ports: clk, rst_n, flush (empties, wins over wr/rd), wr, wr_entry, rd, head, count.
module prefetch_fifo
  import instr_prefetch_buffer_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       wr,
  input  fetch_entry_t               wr_entry,
  input  logic                       rd,
  output fetch_entry_t               head,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  fetch_entry_t    mem [DEPTH];
  logic [AW-1:0]   wp;
  logic [AW-1:0]   rp;
  logic [CW-1:0]   cnt;

  // Power-of-two depth: pointers wrap by natural overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else if (flush) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (wr) begin
        mem[wp] <= wr_entry;
        wp      <= wp + AW'(1);
      end
      if (rd) begin
        rp <= rp + AW'(1);
      end
      cnt <= cnt + CW'(wr) - CW'(rd);
    end
  end

  assign head  = mem[rp];
  assign count = cnt;

endmodule

// File: rtl/instr_prefetch_buffer.sv
// Instruction prefetch buffer: sequential fetch into a small FIFO.
// Ports: clk, rst_n, fetch_en, redirect_valid/pc, mem_rd/addr/rdata,
//   instr_valid/pc/data/ready; stats outputs with PREFETCH_STATS_EN.
module instr_prefetch_buffer
  import instr_prefetch_buffer_pkg::*;
#(
  parameter int          DEPTH   = 4,
  parameter logic [31:0] BOOT_PC = 32'h0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_en,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        mem_rd,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr_pc,
  output logic [31:0] instr_data,
  input  logic        instr_ready
`ifdef PREFETCH_STATS_EN
  ,
  output logic [31:0] stat_fetch_cnt,
  output logic [31:0] stat_drop_cnt
`endif
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

  state_t        state;
  logic [31:0]   pc;
  logic [31:0]   resp_pc;
  logic          inflight;
  logic [CW-1:0] count;
  logic [CW:0]   occ;
  logic          issue;
  logic          pop;
  logic          wr;
  fetch_entry_t  head;
  fetch_entry_t  wr_entry;
  logic          unused_lsb;

  // Low address bits of a redirect target are meaningless.
  assign unused_lsb = ^redirect_pc[1:0];

  // Slots already promised: stored words plus the word still in flight.
  assign occ   = {1'b0, count} + (CW + 1)'(inflight);
  assign issue = (state == RUN) && fetch_en
               && !redirect_valid && (occ < DEPTH_W);

  assign mem_rd   = issue;
  assign mem_addr = word_addr(pc);

  assign instr_valid = (count != '0);
  assign instr_pc    = head.pc;
  assign instr_data  = head.data;

  // A redirect kills both the pop and the returning word.
  assign pop = instr_valid && instr_ready && !redirect_valid;
  assign wr  = inflight && !redirect_valid;

  assign wr_entry.pc   = resp_pc;
  assign wr_entry.data = mem_rdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      pc       <= BOOT_PC;
      resp_pc  <= '0;
      inflight <= 1'b0;
    end else begin
      inflight <= issue;
      if (issue) begin
        resp_pc <= pc;
      end
      if (redirect_valid) begin
        pc <= {redirect_pc[31:2], 2'b00};
      end else if (issue) begin
        pc <= pc + 32'd4;
      end
      if (redirect_valid) begin
        state <= FLUSH;
      end else begin
        unique case (state)
          IDLE,
          RUN,
          FLUSH:   state <= fetch_en ? RUN : IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

  prefetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (redirect_valid),
    .wr       (wr),
    .wr_entry (wr_entry),
    .rd       (pop),
    .head     (head),
    .count    (count)
  );

`ifdef PREFETCH_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_fetch_cnt <= '0;
      stat_drop_cnt  <= '0;
    end else begin
      if (issue) begin
        stat_fetch_cnt <= stat_fetch_cnt + 32'd1;
      end
      if (redirect_valid) begin
        stat_drop_cnt <= stat_drop_cnt + 32'(occ);
      end
    end
  end
`endif

endmodule

// File: tb/tb_instr_prefetch_buffer.sv
// Bench for instr_prefetch_buffer: vector table, corner sequences,
// and random traffic against a queue-based model of the buffer.
module tb_instr_prefetch_buffer;
  import instr_prefetch_buffer_pkg::*;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        fetch_en = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        mem_rd;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;
  logic        instr_valid;
  logic [31:0] instr_pc;
  logic [31:0] instr_data;
  logic        instr_ready = 1'b0;
`ifdef PREFETCH_STATS_EN
  logic [31:0] stat_fetch_cnt;
  logic [31:0] stat_drop_cnt;
`endif

  int vectors = 0;
  int miscompares = 0;

  instr_prefetch_buffer #(
    .DEPTH   (DEPTH),
    .BOOT_PC (32'h0)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .fetch_en       (fetch_en),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .mem_rd         (mem_rd),
    .mem_addr       (mem_addr),
    .mem_rdata      (mem_rdata),
    .instr_valid    (instr_valid),
    .instr_pc       (instr_pc),
    .instr_data     (instr_data),
    .instr_ready    (instr_ready)
`ifdef PREFETCH_STATS_EN
    ,
    .stat_fetch_cnt (stat_fetch_cnt),
    .stat_drop_cnt  (stat_drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] sram_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  // One-cycle-latency SRAM; garbage when not read.
  always @(posedge clk) begin
    mem_rdata <= mem_rd ? sram_word(mem_addr) : 32'hDEAD_BEEF;
  end

  // Reference model: ordered queue of fetched words.
  int           m_mode;
  logic [31:0]  m_pc;
  logic [31:0]  m_pend_pc;
  bit           m_pend;
  fetch_entry_t m_q[$];
  logic [31:0]  m_fetch;
  logic [31:0]  m_drop;

  logic        s_rd;
  logic [31:0] s_addr;
  logic        s_valid;
  logic [31:0] s_pc;
  logic [31:0] s_data;

  task automatic chk(input string n, input logic [31:0] a,
                     input logic [31:0] e);
    vectors++;
    if (a !== e) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
    end
  endtask

  task automatic model_reset();
    m_mode  = 0;
    m_pc    = 32'h0;
    m_pend  = 1'b0;
    m_pend_pc = '0;
    m_q.delete();
    m_fetch = '0;
    m_drop  = '0;
  endtask

  // Called just after a falling edge with inputs applied.
  task automatic tick();
    bit exp_rd;
    int occ;
    fetch_entry_t e;
    #3;
    occ = m_q.size() + (m_pend ? 1 : 0);
    exp_rd = (m_mode == 1) && fetch_en && !redirect_valid
             && (occ < DEPTH);
    s_rd = mem_rd;
    s_addr = mem_addr;
    s_valid = instr_valid;
    s_pc = instr_pc;
    s_data = instr_data;
    chk("mem_rd", 32'(mem_rd), 32'(exp_rd));
    chk("mem_addr", mem_addr, m_pc >> 2);
    chk("instr_valid", 32'(instr_valid), 32'(m_q.size() != 0));
    if (m_q.size() != 0 && instr_valid) begin
      chk("instr_pc", instr_pc, m_q[0].pc);
      chk("instr_data", instr_data, m_q[0].data);
    end
`ifdef PREFETCH_STATS_EN
    chk("stat_fetch", stat_fetch_cnt, m_fetch);
    chk("stat_drop", stat_drop_cnt, m_drop);
`endif
    if (redirect_valid) begin
      m_drop = m_drop + 32'(occ);
      m_q.delete();
      m_pend = 1'b0;
      m_pc = {redirect_pc[31:2], 2'b00};
    end else begin
      if (m_q.size() != 0 && instr_ready) void'(m_q.pop_front());
      if (m_pend) begin
        e.pc = m_pend_pc;
        e.data = sram_word(m_pend_pc >> 2);
        m_q.push_back(e);
      end
      m_pend = exp_rd;
      m_pend_pc = m_pc;
      if (exp_rd) begin
        m_pc = m_pc + 32'd4;
        m_fetch = m_fetch + 32'd1;
      end
    end
    m_mode = redirect_valid ? 2 : (fetch_en ? 1 : 0);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    fetch_en = 1'b0;
    redirect_valid = 1'b0;
    instr_ready = 1'b0;
    #3;
    chk("rst_mem_rd", 32'(mem_rd), 32'h0);
    chk("rst_valid", 32'(instr_valid), 32'h0);
    chk("rst_pc", instr_pc, 32'h0);
    chk("rst_data", instr_data, 32'h0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  // Redirect at T; read at T+2, first word visible at T+4.
  task automatic redirect_seq(input logic [31:0] tgt);
    logic [31:0] base;
    base = {tgt[31:2], 2'b00};
    redirect_valid = 1'b1;
    redirect_pc = tgt;
    tick();
    redirect_valid = 1'b0;
    instr_ready = 1'b1;
    fetch_en = 1'b1;
    tick();
    chk("rdr_t1_rd", 32'(s_rd), 32'h0);
    chk("rdr_t1_valid", 32'(s_valid), 32'h0);
    tick();
    chk("rdr_t2_rd", 32'(s_rd), 32'h1);
    chk("rdr_t2_addr", s_addr, base >> 2);
    tick();
    chk("rdr_t3_valid", 32'(s_valid), 32'h0);
    tick();
    chk("rdr_t4_valid", 32'(s_valid), 32'h1);
    chk("rdr_t4_pc", s_pc, base);
  endtask

  typedef struct {
    bit          fe;
    bit          rdy;
    bit          rd;
    logic [31:0] addr;
    bit          vld;
    logic [31:0] ipc;
  } vec_t;

  vec_t tbl[7];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nrd;
    logic [31:0] last_addr;
    bit seen;
    bit got;
    bit prev_rdr;

    tbl[0] = '{1, 1, 0, 32'd0, 0, 32'h0};
    tbl[1] = '{1, 1, 1, 32'd0, 0, 32'h0};
    tbl[2] = '{1, 1, 1, 32'd1, 0, 32'h0};
    tbl[3] = '{1, 1, 1, 32'd2, 1, 32'h0};
    tbl[4] = '{1, 1, 1, 32'd3, 1, 32'h4};
    tbl[5] = '{1, 1, 1, 32'd4, 1, 32'h8};
    tbl[6] = '{1, 1, 1, 32'd5, 1, 32'hC};

    @(negedge clk);
    do_reset();

    // Sequential stream from BOOT_PC.
    for (int i = 0; i < 7; i++) begin
      fetch_en = tbl[i].fe;
      instr_ready = tbl[i].rdy;
      tick();
      chk("tbl_rd", 32'(s_rd), 32'(tbl[i].rd));
      chk("tbl_addr", s_addr, tbl[i].addr);
      chk("tbl_valid", 32'(s_valid), 32'(tbl[i].vld));
      if (tbl[i].vld) begin
        chk("tbl_pc", s_pc, tbl[i].ipc);
        chk("tbl_data", s_data, sram_word(tbl[i].ipc >> 2));
      end
    end

    // Stalled consumer: fill to DEPTH, one pop gives one read.
    do_reset();
    fetch_en = 1'b1;
    nrd = 0;
    repeat (12) begin
      tick();
      nrd += int'(s_rd);
    end
    chk("fill_reads", 32'(nrd), 32'(DEPTH));
    instr_ready = 1'b1;
    tick();
    chk("fill_head", s_pc, 32'h0);
    instr_ready = 1'b0;
    nrd = 0;
    repeat (6) begin
      tick();
      nrd += int'(s_rd);
    end
    chk("refill_reads", 32'(nrd), 32'h1);

    // Redirect with pop on a full FIFO.
    instr_ready = 1'b1;
    redirect_seq(32'h2000);

    // Redirect while a read is in flight.
    do_reset();
    fetch_en = 1'b1;
    instr_ready = 1'b1;
    repeat (4) tick();
    redirect_seq(32'h1002);

    // Wrap of pc past the top of the address space.
    redirect_seq(32'hFFFF_FFF8);
    repeat (6) tick();

    // fetch_en pause mid-stream.
    do_reset();
    fetch_en = 1'b1;
    instr_ready = 1'b1;
    last_addr = '0;
    repeat (6) begin
      tick();
      if (s_rd) last_addr = s_addr;
    end
    fetch_en = 1'b0;
    seen = 1'b0;
    repeat (5) begin
      tick();
      chk("pause_rd", 32'(s_rd), 32'h0);
      if (s_valid && s_pc == {last_addr[29:0], 2'b00}) seen = 1'b1;
    end
    chk("pause_kept", 32'(seen), 32'h1);
    fetch_en = 1'b1;
    got = 1'b0;
    for (int k = 0; k < 4 && !got; k++) begin
      tick();
      if (s_rd) begin
        got = 1'b1;
        chk("resume_addr", s_addr, last_addr + 32'd1);
      end
    end
    chk("resume_seen", 32'(got), 32'h1);

    // Random traffic with one mid-run reset.
    do_reset();
    prev_rdr = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) begin
        fetch_en = 1'b1;
        instr_ready = 1'b0;
        redirect_valid = 1'b0;
        tick();
        do_reset();
      end
      fetch_en = ($urandom_range(0, 9) != 0);
      instr_ready = ($urandom_range(0, 2) != 0);
      redirect_valid = !prev_rdr && ($urandom_range(0, 29) == 0);
      if ($urandom_range(0, 3) == 0)
        redirect_pc = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
      else
        redirect_pc = $urandom;
      prev_rdr = redirect_valid;
      tick();
    end
    redirect_valid = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
